// File: rtl/street_light_array_ctrl.sv
// Multi-channel street light controller: per-channel debounced day/night FSM stepped by a prescaled
// sample tick, with timed PWM dimming at night and per-channel force on/off modes.
module street_light_array_ctrl #(
    parameter int N_CH      = 4,
    parameter int TICK_DIV  = 200000,
    parameter int DEB_TICKS = 8,
    parameter int DIM_AFTER = 3600,
    parameter int PWM_BITS  = 4,
    parameter int DIM_DUTY  = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [N_CH-1:0]   light_sensor,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   street_light,
    output logic [N_CH-1:0]   night,
    output logic [N_CH-1:0]   dimmed,
    output logic              tick
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int NW = (DIM_AFTER > 0) ? $clog2(DIM_AFTER + 1) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]     DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [NW-1:0]     TMR_MAX   = NW'(DIM_AFTER);
    localparam logic [PWM_BITS:0] DUTY      = (PWM_BITS + 1)'(DIM_DUTY);

    typedef enum logic [1:0] {DAY, DUSK_WAIT, NIGHT, DAWN_WAIT} state_t;

    logic [TW-1:0]       r_tick_cnt;
    logic                r_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [N_CH-1:0]     r_sync1, r_sync2, r_light, r_dimmed;
    state_t              r_state     [N_CH];
    state_t              w_state_nxt [N_CH];
    logic [DW-1:0]       r_deb       [N_CH];
    logic [DW-1:0]       w_deb_nxt   [N_CH];
    logic [NW-1:0]       r_tmr       [N_CH];
    logic [NW-1:0]       w_tmr_nxt   [N_CH];
    logic [N_CH-1:0]     w_night, w_dim_cond, w_light_nxt;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_pwm_cnt  <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_light    <= '0;
            r_dimmed   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= DAY;
                r_deb[i]   <= '0;
                r_tmr[i]   <= '0;
            end
        end else begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
            r_tick     <= (r_tick_cnt == TICK_LAST);
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_sync1    <= light_sensor;
            r_sync2    <= r_sync1;
            r_light    <= w_light_nxt;
            r_dimmed   <= w_dim_cond;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_deb[i]   <= w_deb_nxt[i];
                r_tmr[i]   <= w_tmr_nxt[i];
            end
        end
    end

    // Debounce FSMs: state, debounce count and night timer only move on a sample tick.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_deb_nxt[i]   = r_deb[i];
            w_tmr_nxt[i]   = r_tmr[i];
            if (r_tick) begin
                case (r_state[i])
                    DAY: begin
                        if (r_sync2[i]) begin
                            if (DEB_TICKS == 1) begin
                                w_state_nxt[i] = NIGHT;
                            end else begin
                                w_state_nxt[i] = DUSK_WAIT;
                                w_deb_nxt[i]   = DW'(1);
                            end
                        end
                    end
                    DUSK_WAIT: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt[i] = DAY;
                            w_tmr_nxt[i]   = '0;
                        end else if (r_deb[i] == DEB_LAST) begin
                            w_state_nxt[i] = NIGHT;
                        end else begin
                            w_deb_nxt[i] = r_deb[i] + 1'b1;
                        end
                    end
                    NIGHT: begin
                        if (!r_sync2[i]) begin
                            if (DEB_TICKS == 1) begin
                                w_state_nxt[i] = DAY;
                                w_tmr_nxt[i]   = '0;
                            end else begin
                                w_state_nxt[i] = DAWN_WAIT;
                                w_deb_nxt[i]   = DW'(1);
                            end
                        end else if (r_tmr[i] != TMR_MAX) begin
                            w_tmr_nxt[i] = r_tmr[i] + 1'b1;
                        end
                    end
                    DAWN_WAIT: begin
                        if (r_sync2[i]) begin
                            w_state_nxt[i] = NIGHT;
                        end else if (r_deb[i] == DEB_LAST) begin
                            w_state_nxt[i] = DAY;
                            w_tmr_nxt[i]   = '0;
                        end else begin
                            w_deb_nxt[i] = r_deb[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Lamp drive: force modes win; dimming only applies in plain auto mode once the timer saturates.
    always_comb begin
        w_night     = '0;
        w_dim_cond  = '0;
        w_light_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_night[i]    = (r_state[i] == NIGHT) || (r_state[i] == DAWN_WAIT);
            w_dim_cond[i] = (DIM_AFTER != 0) && (r_tmr[i] == TMR_MAX) &&
                            (mode[2*i +: 2] == 2'b00) && w_night[i];
            case (mode[2*i +: 2])
                2'b01:   w_light_nxt[i] = 1'b0;
                2'b10:   w_light_nxt[i] = 1'b1;
                default: w_light_nxt[i] = w_dim_cond[i] ? ({1'b0, r_pwm_cnt} < DUTY) : w_night[i];
            endcase
        end
    end

    assign street_light = r_light;
    assign night        = w_night;
    assign dimmed       = r_dimmed;
    assign tick         = r_tick;

endmodule

// File: tb/tb_street_light_array_ctrl.sv
// Directed bench for street_light_array_ctrl with a small, fast configuration (2 channels, tick every 4 clocks).
module tb_street_light_array_ctrl;
    logic       clk_in;
    logic       reset;
    logic [1:0] light_sensor;
    logic [3:0] mode;
    logic [1:0] street_light;
    logic [1:0] night;
    logic [1:0] dimmed;
    logic       tick;

    int checks = 0;
    int errors = 0;

    street_light_array_ctrl #(
        .N_CH(2), .TICK_DIV(4), .DEB_TICKS(3), .DIM_AFTER(5), .PWM_BITS(2), .DIM_DUTY(1)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .light_sensor(light_sensor),
        .mode(mode),
        .street_light(street_light),
        .night(night),
        .dimmed(dimmed),
        .tick(tick)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge one cycle after a tick pulse, i.e. just after the FSMs stepped.
    task automatic after_tick();
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (tick !== 1'b1 && n < 8);
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout observed=%b expected=1", tick);
        end
        @(negedge clk_in);
    endtask

    initial begin
        reset        = 1'b0;
        light_sensor = 2'b00;
        mode         = 4'b0000;
        repeat (3) @(negedge clk_in);
        chk("rst_light", {2'b00, street_light}, 4'b0000);
        chk("rst_night", {2'b00, night}, 4'b0000);
        chk("rst_dimmed", {2'b00, dimmed}, 4'b0000);
        chk("rst_tick", {3'b000, tick}, 4'b0000);

        // 1: tick cadence after release
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            chk($sformatf("tick_c%0d", k), {3'b000, tick}, {3'b000, (k % 4 == 0)});
        end
        @(negedge clk_in);
        chk("idle_night", {2'b00, night}, 4'b0000);
        chk("idle_light", {2'b00, street_light}, 4'b0000);

        // 3a: dusk glitch of two ticks is rejected
        light_sensor = 2'b01;
        after_tick();
        chk("dusk_g1_night", {2'b00, night}, 4'b0000);
        after_tick();
        chk("dusk_g2_night", {2'b00, night}, 4'b0000);
        light_sensor = 2'b00;
        after_tick();
        chk("dusk_g3_night", {2'b00, night}, 4'b0000);
        @(negedge clk_in);
        chk("dusk_g_light", {2'b00, street_light}, 4'b0000);

        // 2: full debounce into NIGHT on channel 0
        after_tick();
        light_sensor = 2'b01;
        after_tick();
        chk("dusk_t1_night", {2'b00, night}, 4'b0000);
        after_tick();
        chk("dusk_t2_night", {2'b00, night}, 4'b0000);
        after_tick();
        chk("dusk_t3_night", {2'b00, night}, 4'b0001);
        chk("dusk_t3_light_lag", {2'b00, street_light}, 4'b0000);
        @(negedge clk_in);
        chk("night_light", {2'b00, street_light}, 4'b0001);

        // 3b: dawn glitch of two ticks keeps the lamp on
        light_sensor = 2'b00;
        after_tick();
        chk("dawn_g1_night", {2'b00, night}, 4'b0001);
        chk("dawn_g1_light", {2'b00, street_light}, 4'b0001);
        after_tick();
        chk("dawn_g2_night", {2'b00, night}, 4'b0001);
        light_sensor = 2'b01;
        after_tick();
        chk("dawn_g3_night", {2'b00, night}, 4'b0001);
        @(negedge clk_in);
        chk("dawn_g_light", {2'b00, street_light}, 4'b0001);

        // 4a: five night ticks then PWM dimming 1,0,0,0
        for (int t = 1; t <= 4; t++) begin
            after_tick();
            chk($sformatf("predim_t%0d", t), {2'b00, dimmed}, 4'b0000);
        end
        after_tick();
        chk("dim_entry_lag", {2'b00, dimmed}, 4'b0000);
        chk("dim_entry_light", {2'b00, street_light}, 4'b0001);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk_in);
            chk($sformatf("pwm_k%0d", k), {2'b00, street_light}, {3'b000, (k % 4 == 1)});
            chk($sformatf("dimmed_k%0d", k), {2'b00, dimmed}, 4'b0001);
        end

        // 5: mode 11 undims, mode 01 forces off at night
        mode = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk($sformatf("m11_light%0d", k), {2'b00, street_light}, 4'b0001);
            chk($sformatf("m11_dimmed%0d", k), {2'b00, dimmed}, 4'b0000);
        end
        mode = 4'b0001;
        @(negedge clk_in);
        chk("m01_light", {2'b00, street_light}, 4'b0000);
        chk("m01_night", {2'b00, night}, 4'b0001);
        mode = 4'b0000;
        @(negedge clk_in);
        chk("m00_redim", {2'b00, dimmed}, 4'b0001);

        // 4b: three dark-free ticks return to DAY and clear dimming
        after_tick();
        light_sensor = 2'b00;
        after_tick();
        chk("dawn_t1_night", {2'b00, night}, 4'b0001);
        chk("dawn_t1_dimmed", {2'b00, dimmed}, 4'b0001);
        after_tick();
        chk("dawn_t2_night", {2'b00, night}, 4'b0001);
        after_tick();
        chk("dawn_t3_night", {2'b00, night}, 4'b0000);
        @(negedge clk_in);
        chk("day_dimmed", {2'b00, dimmed}, 4'b0000);
        chk("day_light", {2'b00, street_light}, 4'b0000);

        // 5a: force on during the day
        mode = 4'b0010;
        @(negedge clk_in);
        chk("m10_light", {2'b00, street_light}, 4'b0001);
        chk("m10_night", {2'b00, night}, 4'b0000);
        mode = 4'b0000;
        @(negedge clk_in);
        chk("m10_release", {2'b00, street_light}, 4'b0000);

        // 6: asynchronous reset while dimmed, then simultaneous re-entry on both channels
        after_tick();
        light_sensor = 2'b01;
        repeat (8) after_tick();
        @(negedge clk_in);
        chk("pre_rst_dimmed", {2'b00, dimmed}, 4'b0001);
        #2 reset = 1'b0;
        #1;
        chk("arst_light", {2'b00, street_light}, 4'b0000);
        chk("arst_night", {2'b00, night}, 4'b0000);
        chk("arst_dimmed", {2'b00, dimmed}, 4'b0000);
        chk("arst_tick", {3'b000, tick}, 4'b0000);
        light_sensor = 2'b11;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        after_tick();
        chk("re_t1_night", {2'b00, night}, 4'b0000);
        after_tick();
        chk("re_t2_night", {2'b00, night}, 4'b0000);
        after_tick();
        chk("re_t3_night", {2'b00, night}, 4'b0011);
        @(negedge clk_in);
        chk("re_light", {2'b00, street_light}, 4'b0011);
        chk("re_dimmed", {2'b00, dimmed}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
